matmul_sequencer: RTL and testbench
===================================

# matmul_sequencer

Controller that sequences the N×N output-stationary systolic multiply array: accepts one A/B operand pair over a valid/ready handshake, clears the array, drives the skewed row/column feed (including the B column indexing), steps the array exactly 3N-2 times, then holds the captured C matrix until the consumer takes it. It sits between the job source and the element array, and is the only block that drives the array's step enable and operand edges.

## Interface
- `N`, default 4: matrix dimension.
- `W`, default 8: element width in bits, for operands and results.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  job offered.
- `req_ready`  out  1  high only in IDLE.
- `req_a`  in  N×N×W  matrix A, row-major.
- `req_b`  in  N×N×W  matrix B, row-major.
- `arr_clear`  out  1  synchronous accumulator clear to the array.
- `arr_en`  out  1  array step enable.
- `arr_a_in`  out  N×W  row feeds at column 0.
- `arr_b_in`  out  N×W  column feeds at row 0.
- `arr_c`  in  N×N×W  array accumulators.
- `rsp_valid`  out  1  result held.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_c`  out  N×N×W  registered result.
- `busy`  out  1  state ≠ IDLE.

## Operation
- States: IDLE → CLEAR → RUN → CAPTURE → DONE → IDLE.
- **IDLE:** if `req_valid`, latch `req_a`/`req_b` into operand registers and go to CLEAR.
- **CLEAR:** lasts 1 cycle and asserts `arr_clear`. Step counter `s` is set to 0.
- **RUN:** `arr_en` = 1 for 3N-2 cycles, with `s` = 0 … 3N-3.
  - `arr_a_in[i] = A[i][s-i]` when 0 ≤ s-i < N, else 0.
  - `arr_b_in[j] = B[s-j][j]` when 0 ≤ s-j < N, else 0.
  - Leave RUN after `s` = 3N-3.
- **CAPTURE:** lasts 1 cycle; `rsp_c` ← `arr_c`.
- **DONE:** `rsp_valid` = 1. On `rsp_valid && rsp_ready`, go to IDLE.
- Outside RUN: `arr_en` = 0 and all feeds are 0.
- Outside CLEAR: `arr_clear` = 0.
- `rsp_c` holds its value until the next CAPTURE.
- Arithmetic: products and sums are modulo 2^W, identical to the element. The sequencer does no arithmetic on data.
- `s` width is clog2(3N-1) bits. It never wraps, because it stops at 3N-3.
- `req_valid` outside IDLE is ignored; operands are not re-latched.
- Reset values: state = IDLE, `s` = 0, `rsp_c` = 0, `rsp_valid` = 0, `req_ready` = 1, `busy` = 0, `arr_en` = 0, `arr_clear` = 0, feeds = 0.
- Reset mid-job: the job is dropped with no response. The array is reset by the same `reset` net.

## Timing
- Acceptance edge = E0.
  - CLEAR runs in the cycle after E0.
  - RUN covers edges E1 … E(3N-2).
  - CAPTURE is at E(3N-1).
  - `rsp_valid` rises at E(3N). For N = 4 that is 12 edges.
- `rsp_ready` already high on entry to DONE: DONE lasts exactly 1 cycle, and `req_ready` is high the following cycle.
- Minimum job-to-job spacing is 3N+2 edges. No request is accepted while in DONE.
- All outputs are driven from registers or from registered state and `s`. There is no combinational input→output path except through latched operands.

## Configuration
- `MATMUL_SEQ_ABORT_EN`
  - **Defined:** adds input `abort` (1 bit). While `abort` = 1 in CLEAR, RUN or CAPTURE:
    - go to IDLE next edge;
    - assert `arr_clear` that same cycle;
    - force `arr_en` = 0;
    - leave `rsp_c` unchanged and do not raise `rsp_valid`.
  - `abort` is ignored in IDLE and DONE. In IDLE, `abort` together with `req_valid` still accepts the job.
  - **Undefined:** no port, and no abort logic is compiled.

## Structure
- Package `matmul_pkg` holds:
  - the state enum `seq_state_t`;
  - the default element width constant;
  - the step-width function clog2(3N-1).
- Sub-module `matmul_skew_feed` is combinational: (`s`, operand registers, run flag) → `arr_a_in`/`arr_b_in`. It contains the row/column index masking.
- FSM, counter, handshakes and capture stay in `matmul_sequencer`.

## Test plan
- **All-ones:** N = 4, A = all 1, B = all 1, `rsp_ready` = 1. Expect `rsp_c` = all 4, `rsp_valid` at edge 12 after acceptance, and `arr_en` high exactly 10 cycles.
- **Identity:** A = I, B[i][j] = 4i+j. Expect `rsp_c` = B, and `arr_b_in[j]` at `s` = 5 equal to B[5-j][j] for j = 2, 3 and 0 otherwise.
- **Overflow wrap:** A = B = all 16. Expect `rsp_c` = all 0 (1024 mod 256).
- **Back-pressure:**
  - Hold `rsp_ready` low 5 cycles in DONE: `rsp_valid`/`rsp_c` stable, `req_ready` = 0, and a second `req_valid` is not accepted.
  - Then raise `rsp_ready`: IDLE next cycle, and the second job is accepted on the following edge.
- **Reset mid-RUN:** assert `reset` low at `s` = 3. All outputs reach their reset values immediately; after release `rsp_valid` stays 0 and `req_ready` = 1.
- **Abort (`MATMUL_SEQ_ABORT_EN`):**
  - `abort` at `s` = 4: `arr_clear` = 1 that cycle, IDLE next, `rsp_c` keeps the previous result.
  - A following all-ones job returns all 4.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared types and constants for the matmul sequencer slice.
// Holds the sequencer state enum, default sizes and the step-counter width helper.
package matmul_pkg;

    localparam int DEFAULT_N = 4;
    localparam int DEFAULT_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_CAPTURE,
        ST_DONE
    } seq_state_t;

    // Counter must hold 0 .. 3N-3, so clog2(3N-1) bits suffice.
    function automatic int step_width(input int n);
        return $clog2(3 * n - 1);
    endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// Job request / result response channel between the job source, the consumer and the sequencer.
// Matrices are flattened row-major: element (r,c) sits at bits [(r*N+c)*W +: W].
interface matmul_sequencer_if
    import matmul_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = DEFAULT_W
) ();

    logic             req_valid;
    logic             req_ready;
    logic [N*N*W-1:0] req_a;
    logic [N*N*W-1:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [N*N*W-1:0] rsp_c;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_c
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_c
    );

endinterface

// File: rtl/matmul_skew_feed.sv
// Combinational skewed edge feed for the systolic array.
// Row i carries A[i][s-i] and column j carries B[s-j][j] while running, zero when out of range.
module matmul_skew_feed
    import matmul_pkg::*;
#(
    parameter int N  = DEFAULT_N,
    parameter int W  = DEFAULT_W,
    parameter int SW = step_width(N)
) (
    input  logic [SW-1:0]    s,
    input  logic [N*N*W-1:0] a_op,
    input  logic [N*N*W-1:0] b_op,
    input  logic             run,
    output logic [N*W-1:0]   a_in,
    output logic [N*W-1:0]   b_in
);

    // Matching every candidate k against s keeps all selects constant-indexed.
    always_comb begin
        a_in = '0;
        b_in = '0;
        if (run) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (int'(s) == i + k) begin
                        a_in[i*W +: W] = a_op[(i*N+k)*W +: W];
                        b_in[i*W +: W] = b_op[(k*N+i)*W +: W];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Sequencer for the NxN output-stationary systolic multiply array: latch, clear, skewed feed, capture, hold.
// Optional MATMUL_SEQ_ABORT_EN adds an 'abort' input that drops a job in CLEAR/RUN/CAPTURE.
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = DEFAULT_W
) (
    input  logic                   clock,
    input  logic                   reset,
    matmul_sequencer_if.slave      bus,
`ifdef MATMUL_SEQ_ABORT_EN
    input  logic                   abort,
`endif
    output logic                   arr_clear,
    output logic                   arr_en,
    output logic [N*W-1:0]         arr_a_in,
    output logic [N*W-1:0]         arr_b_in,
    input  logic [N*N*W-1:0]       arr_c,
    output logic                   busy
);

    localparam int            SW     = step_width(N);
    localparam logic [SW-1:0] S_LAST = SW'(3 * N - 3);

    seq_state_t       state_q, state_d;
    logic [SW-1:0]    s_q, s_d;
    logic [N*N*W-1:0] a_q, a_d;
    logic [N*N*W-1:0] b_q, b_d;
    logic [N*N*W-1:0] rsp_c_q, rsp_c_d;
    logic             run;

`ifdef MATMUL_SEQ_ABORT_EN
    logic abort_hit;
    assign abort_hit = abort &&
                       (state_q == ST_CLEAR || state_q == ST_RUN || state_q == ST_CAPTURE);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            rsp_c_q <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rsp_c_q <= rsp_c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        a_d     = a_q;
        b_d     = b_q;
        rsp_c_d = rsp_c_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    a_d     = bus.req_a;
                    b_d     = bus.req_b;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                s_d     = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (s_q == S_LAST) begin
                    state_d = ST_CAPTURE;
                end else begin
                    s_d = s_q + SW'(1);
                end
            end
            ST_CAPTURE: begin
                rsp_c_d = arr_c;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef MATMUL_SEQ_ABORT_EN
        // An abort in CAPTURE must not disturb the previously held result.
        if (abort_hit) begin
            state_d = ST_IDLE;
            rsp_c_d = rsp_c_q;
        end
`endif
    end

    always_comb begin
        run           = (state_q == ST_RUN);
        arr_en        = run;
        arr_clear     = (state_q == ST_CLEAR);
        busy          = (state_q != ST_IDLE);
        bus.req_ready = (state_q == ST_IDLE);
        bus.rsp_valid = (state_q == ST_DONE);
`ifdef MATMUL_SEQ_ABORT_EN
        if (abort_hit) begin
            arr_en    = 1'b0;
            arr_clear = 1'b1;
        end
`endif
    end

    assign bus.rsp_c = rsp_c_q;

    matmul_skew_feed #(
        .N  (N),
        .W  (W),
        .SW (SW)
    ) u_skew_feed (
        .s    (s_q),
        .a_op (a_q),
        .b_op (b_q),
        .run  (run),
        .a_in (arr_a_in),
        .b_in (arr_b_in)
    );

endmodule

// File: tb/tb_matmul_sequencer.sv
// Testbench for matmul_sequencer: behavioural systolic array, vector table, response scoreboard.
// Define MATMUL_SEQ_ABORT_EN to also exercise the abort path.
module tb_matmul_sequencer;
    import matmul_pkg::*;

    localparam int N = 4;
    localparam int W = 8;

    typedef logic [N*N*W-1:0] mat_t;
    typedef logic [N*W-1:0]   vec_t;

    typedef struct {
        mat_t a;
        mat_t b;
        mat_t exp_c;
    } vec_rec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    matmul_sequencer_if #(.N(N), .W(W)) bus ();

    logic arr_clear;
    logic arr_en;
    vec_t arr_a_in;
    vec_t arr_b_in;
    mat_t arr_c;
    logic busy;
`ifdef MATMUL_SEQ_ABORT_EN
    logic abort = 1'b0;
`endif

    int   checks = 0;
    int   errors = 0;
    mat_t sb[$];

    matmul_sequencer #(.N(N), .W(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
`ifdef MATMUL_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .arr_clear (arr_clear),
        .arr_en    (arr_en),
        .arr_a_in  (arr_a_in),
        .arr_b_in  (arr_b_in),
        .arr_c     (arr_c),
        .busy      (busy)
    );

    // Output-stationary array: operands move right/down one PE per enabled step.
    logic [W-1:0] pa [N][N];
    logic [W-1:0] pb [N][N];
    logic [W-1:0] pc [N][N];

    always @(posedge clock or negedge reset) begin
        if (!reset || arr_clear) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    pa[i][j] <= '0;
                    pb[i][j] <= '0;
                    pc[i][j] <= '0;
                end
            end
        end else if (arr_en) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    logic [W-1:0] l;
                    logic [W-1:0] t;
                    if (j == 0) l = arr_a_in[i*W +: W];
                    else        l = pa[i][j-1];
                    if (i == 0) t = arr_b_in[j*W +: W];
                    else        t = pb[i-1][j];
                    pa[i][j] <= l;
                    pb[i][j] <= t;
                    pc[i][j] <= pc[i][j] + l * t;
                end
            end
        end
    end

    always_comb begin
        arr_c = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                arr_c[(i*N+j)*W +: W] = pc[i][j];
            end
        end
    end

    function automatic logic [W-1:0] el(input mat_t m, input int r, input int c);
        return m[(r*N+c)*W +: W];
    endfunction

    function automatic mat_t mm(input mat_t a, input mat_t b);
        mat_t         c;
        logic [W-1:0] acc;
        c = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                acc = '0;
                for (int k = 0; k < N; k++) acc = acc + el(a, i, k) * el(b, k, j);
                c[(i*N+j)*W +: W] = acc;
            end
        end
        return c;
    endfunction

    function automatic mat_t fill(input logic [W-1:0] v);
        mat_t m;
        for (int e = 0; e < N*N; e++) m[e*W +: W] = v;
        return m;
    endfunction

    function automatic mat_t rand_mat();
        mat_t m;
        for (int e = 0; e < N*N; e++) m[e*W +: W] = W'($urandom_range(0, 255));
        return m;
    endfunction

    task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard consumer: the handshake completes on the next rising edge.
    always @(negedge clock) begin
        mat_t e;
        if (reset && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rsp actual=%0h expected=none", bus.rsp_c);
            end else begin
                e = sb.pop_front();
                check_output("rsp_c", bus.rsp_c, e);
            end
        end
    end

    // Full job with rsp_ready high; also checks latency, step count and s=5 feeds.
    task automatic apply_stimulus(input mat_t a, input mat_t b, input mat_t exp_c);
        int   lat;
        int   en_cnt;
        int   guard;
        vec_t a5;
        vec_t b5;
        vec_t ea5;
        vec_t eb5;
        guard = 0;
        while (!bus.req_ready && guard < 50) begin
            tick();
            guard++;
        end
        check_output("req_ready_before_job", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        sb.push_back(exp_c);
        tick();
        bus.req_valid = 1'b0;
        check_output("clear_cycle", {arr_clear, arr_en, busy}, 3'b101);
        lat    = 0;
        en_cnt = 0;
        a5     = '0;
        b5     = '0;
        while (!bus.rsp_valid && lat < 100) begin
            tick();
            lat++;
            if (arr_en) begin
                if (en_cnt == 5) begin
                    a5 = arr_a_in;
                    b5 = arr_b_in;
                end
                en_cnt++;
            end
        end
        check_output("rsp_latency", lat, 3*N);
        check_output("arr_en_cycles", en_cnt, 3*N-2);
        ea5 = '0;
        eb5 = '0;
        for (int i = 0; i < N; i++) begin
            if (5 - i >= 0 && 5 - i < N) begin
                ea5[i*W +: W] = el(a, i, 5 - i);
                eb5[i*W +: W] = el(b, 5 - i, i);
            end
        end
        check_output("a_feed_s5", a5, ea5);
        check_output("b_feed_s5", b5, eb5);
        tick();
        check_output("idle_after_done", {bus.req_ready, bus.rsp_valid, busy}, 3'b100);
    endtask

    vec_rec_t vecs [4];
    mat_t     ident;
    mat_t     bidx;
    mat_t     ra;
    mat_t     rb;
    mat_t     prev;
    int       guard;
    int       en_cnt;
    logic     seen_valid;

    initial begin
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;

        ident = '0;
        bidx  = '0;
        for (int i = 0; i < N; i++) begin
            ident[(i*N+i)*W +: W] = 8'd1;
            for (int j = 0; j < N; j++) bidx[(i*N+j)*W +: W] = W'(4*i + j);
        end
        ra = rand_mat();
        rb = rand_mat();
        vecs[0] = '{a: fill(8'd1),  b: fill(8'd1),  exp_c: fill(8'd4)};
        vecs[1] = '{a: ident,       b: bidx,        exp_c: bidx};
        vecs[2] = '{a: fill(8'd16), b: fill(8'd16), exp_c: fill(8'd0)};
        vecs[3] = '{a: ra,          b: rb,          exp_c: mm(ra, rb)};

        // Reset values
        repeat (2) @(posedge clock);
        #1;
        check_output("reset_ctrl", {bus.req_ready, busy, bus.rsp_valid, arr_en, arr_clear}, 5'b10000);
        check_output("reset_rsp_c", bus.rsp_c, '0);
        check_output("reset_feeds", {arr_a_in, arr_b_in}, '0);
        reset = 1'b1;
        tick();

        for (int v = 0; v < 4; v++) apply_stimulus(vecs[v].a, vecs[v].b, vecs[v].exp_c);
        check_output("rsp_c_hold", bus.rsp_c, vecs[3].exp_c);

        // Back-pressure in DONE with a competing request
        bus.rsp_ready = 1'b0;
        ra = rand_mat();
        rb = rand_mat();
        prev = mm(ra, rb);
        bus.req_valid = 1'b1;
        bus.req_a     = ra;
        bus.req_b     = rb;
        sb.push_back(prev);
        tick();
        bus.req_valid = 1'b0;
        guard = 0;
        while (!bus.rsp_valid && guard < 100) begin
            tick();
            guard++;
        end
        check_output("bp_rsp_valid", bus.rsp_valid, 1);
        bus.req_valid = 1'b1;
        bus.req_a     = fill(8'd1);
        bus.req_b     = fill(8'd1);
        for (int c = 0; c < 5; c++) begin
            check_output("bp_ctrl", {bus.rsp_valid, bus.req_ready, busy}, 3'b101);
            check_output("bp_rsp_c", bus.rsp_c, prev);
            tick();
        end
        check_output("bp_still_done", {bus.rsp_valid, busy}, 2'b11);
        bus.rsp_ready = 1'b1;
        sb.push_back(fill(8'd4));
        tick();
        check_output("bp_idle", {bus.req_ready, busy, bus.rsp_valid}, 3'b100);
        tick();
        bus.req_valid = 1'b0;
        check_output("bp_second_accept", {bus.req_ready, busy, arr_clear}, 3'b011);
        guard = 0;
        while (!bus.rsp_valid && guard < 100) begin
            tick();
            guard++;
        end
        check_output("bp_second_done", bus.rsp_valid, 1);
        tick();

        // Reset during RUN at s = 3
        bus.req_valid = 1'b1;
        bus.req_a     = rand_mat();
        bus.req_b     = rand_mat();
        tick();
        bus.req_valid = 1'b0;
        en_cnt = 0;
        guard  = 0;
        while (en_cnt < 4 && guard < 30) begin
            tick();
            guard++;
            if (arr_en) en_cnt++;
        end
        check_output("mid_run_reached_s3", en_cnt, 4);
        #2;
        reset = 1'b0;
        #1;
        check_output("mid_reset_ctrl", {bus.req_ready, busy, bus.rsp_valid, arr_en, arr_clear}, 5'b10000);
        check_output("mid_reset_rsp_c", bus.rsp_c, '0);
        check_output("mid_reset_feeds", {arr_a_in, arr_b_in}, '0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        seen_valid = 1'b0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (bus.rsp_valid) seen_valid = 1'b1;
        end
        check_output("post_reset_no_rsp", {seen_valid, bus.req_ready}, 2'b01);

`ifdef MATMUL_SEQ_ABORT_EN
        ra = rand_mat();
        rb = rand_mat();
        prev = mm(ra, rb);
        apply_stimulus(ra, rb, prev);
        bus.req_valid = 1'b1;
        bus.req_a     = fill(8'd1);
        bus.req_b     = fill(8'd1);
        tick();
        bus.req_valid = 1'b0;
        en_cnt = 0;
        guard  = 0;
        while (en_cnt < 5 && guard < 30) begin
            tick();
            guard++;
            if (arr_en) en_cnt++;
        end
        abort = 1'b1;
        #1;
        check_output("abort_same_cycle", {arr_clear, arr_en}, 2'b10);
        tick();
        abort = 1'b0;
        check_output("abort_idle", {bus.req_ready, busy, bus.rsp_valid}, 3'b100);
        check_output("abort_rsp_c_kept", bus.rsp_c, prev);
        abort         = 1'b1;
        bus.req_valid = 1'b1;
        sb.push_back(fill(8'd4));
        tick();
        abort         = 1'b0;
        bus.req_valid = 1'b0;
        check_output("abort_idle_accept", busy, 1);
        guard = 0;
        while (!bus.rsp_valid && guard < 100) begin
            tick();
            guard++;
        end
        check_output("abort_next_done", bus.rsp_valid, 1);
        tick();
`endif

        repeat (3) tick();
        check_output("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
